// File: rtl/ps2_hotkeys.sv
// PS/2 hotkey decoder: tracks level, edge pulses, toggle and long-hold state
// for a parameterised table of {extended, scancode} entries.
module ps2_hotkeys #(
    parameter int                KEYS  = 8,
    parameter logic [9*KEYS-1:0] CODES = {KEYS{9'h000}},
    parameter int                HOLDW = 22,
    parameter logic [HOLDW-1:0]  HOLD  = 22'd3000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce,
    input  logic            strb,
    input  logic [7:0]      code,
    output logic [KEYS-1:0] keys,
    output logic [KEYS-1:0] press,
    // "release" is a reserved word, hence the past-tense name
    output logic [KEYS-1:0] released,
    output logic [KEYS-1:0] toggle,
    output logic [KEYS-1:0] held,
    output logic            brk,
    output logic            extd
);

    logic [KEYS-1:0] prev_keys;
    logic [KEYS-1:0] keys_nxt;
    logic [KEYS-1:0] held_nxt;
    logic [2:0]      skip;
    logic [2:0]      skip_nxt;
    logic            brk_nxt;
    logic            extd_nxt;
    logic            clear_all;

    always_comb begin
        keys_nxt  = keys;
        brk_nxt   = brk;
        extd_nxt  = extd;
        skip_nxt  = skip;
        clear_all = 1'b0;
        if (strb) begin
            if (skip != 3'd0) begin
                skip_nxt = skip - 3'd1;
            end else if (code == 8'hF0) begin
                brk_nxt = 1'b1;
            end else if (code == 8'hE0) begin
                extd_nxt = 1'b1;
            end else if (code == 8'hE1) begin
                // Pause: E1 is followed by seven bytes that must not decode
                skip_nxt = 3'd7;
                brk_nxt  = 1'b0;
                extd_nxt = 1'b0;
            end else if (code == 8'hAA && !brk) begin
                keys_nxt  = '1;
                clear_all = 1'b1;
                brk_nxt   = 1'b0;
                extd_nxt  = 1'b0;
            end else begin
                for (int i = 0; i < KEYS; i++) begin
                    if (CODES[9*i +: 8] == code && CODES[9*i+8] == extd)
                        keys_nxt[i] = brk;
                end
                brk_nxt  = 1'b0;
                extd_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keys      <= '1;
            prev_keys <= '1;
            press     <= '0;
            released  <= '0;
            toggle    <= '0;
            held      <= '0;
            brk       <= 1'b0;
            extd      <= 1'b0;
            skip      <= 3'd0;
        end else if (ce) begin
            keys      <= keys_nxt;
            // keyboard BAT forces everything up without a release edge
            prev_keys <= clear_all ? {KEYS{1'b1}} : keys;
            press     <= prev_keys & ~keys;
            released  <= ~prev_keys & keys;
            toggle    <= toggle ^ (prev_keys & ~keys);
            held      <= held_nxt;
            brk       <= brk_nxt;
            extd      <= extd_nxt;
            skip      <= skip_nxt;
        end
    end

    for (genvar i = 0; i < KEYS; i++) begin : g_hold
        logic [HOLDW-1:0] cnt;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (ce) begin
                if (keys[i])
                    cnt <= '0;
                else if (cnt != HOLD)
                    cnt <= cnt + {{(HOLDW-1){1'b0}}, 1'b1};
            end
        end

        assign held_nxt[i] = (cnt == HOLD) && !keys[i];
    end

endmodule

// File: tb/tb_ps2_hotkeys.sv
// Scoreboard bench for ps2_hotkeys: expected press/release events are queued
// as bytes are sent and popped by a monitor that watches the pulse outputs.
module tb_ps2_hotkeys;

    localparam int          KEYS  = 3;
    localparam logic [26:0] CODES = {9'h171, 9'h014, 9'h007};

    logic            clock = 1'b0;
    logic            rst_n;
    logic            ce;
    logic            strb;
    logic [7:0]      code;
    logic [KEYS-1:0] keys;
    logic [KEYS-1:0] press;
    logic [KEYS-1:0] released;
    logic [KEYS-1:0] toggle;
    logic [KEYS-1:0] held;
    logic            brk;
    logic            extd;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [7:0]      exp_q[$];
    logic [7:0]      mon_obs;
    logic [7:0]      mon_exp;
    logic [KEYS-1:0] tog_exp = '0;

    always #5 clock = ~clock;

    ps2_hotkeys #(
        .KEYS (KEYS),
        .CODES(CODES),
        .HOLDW(22),
        .HOLD (22'd100)
    ) dut (
        .clock   (clock),
        .reset   (rst_n),
        .ce      (ce),
        .strb    (strb),
        .code    (code),
        .keys    (keys),
        .press   (press),
        .released(released),
        .toggle  (toggle),
        .held    (held),
        .brk     (brk),
        .extd    (extd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_press(input int i);
        exp_q.push_back({4'h1, 4'(i)});
        tog_exp[i] = ~tog_exp[i];
    endtask

    task automatic expect_release(input int i);
        exp_q.push_back({4'h2, 4'(i)});
    endtask

    task automatic ce_tick();
        @(negedge clock);
        ce = 1'b1;
        @(negedge clock);
        ce = 1'b0;
    endtask

    task automatic settle();
        ce_tick();
        ce_tick();
    endtask

    // strb stays high across one non-ce clock; it must be taken only once
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        strb = 1'b1;
        code = b;
        ce   = 1'b1;
        @(negedge clock);
        ce   = 1'b0;
        @(negedge clock);
        strb = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check(tag, exp_q.size(), 0);
    endtask

    always @(posedge clock) begin
        if (ce && rst_n) begin
            #1;
            for (int i = 0; i < KEYS; i++) begin
                if (press[i]) begin
                    mon_obs = {4'h1, 4'(i)};
                    mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                    check("pulse", mon_obs, mon_exp);
                end
                if (released[i]) begin
                    mon_obs = {4'h2, 4'(i)};
                    mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                    check("pulse", mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        strb  = 1'b0;
        code  = 8'h00;
        #23;
        check("rst_keys", keys, 3'b111);
        check("rst_press", press, 3'b000);
        check("rst_release", released, 3'b000);
        check("rst_toggle", toggle, 3'b000);
        check("rst_held", held, 3'b000);
        check("rst_brk", brk, 1'b0);
        check("rst_extd", extd, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        ce_tick();

        // F12 make: pulse lands one ce after the keys update
        expect_press(0);
        send(8'h07);
        check("f12_keys", keys, 3'b110);
        ce_tick();
        check("press_lat", press, 3'b001);
        ce_tick();
        check("press_width", press, 3'b000);
        check("f12_toggle", toggle, tog_exp);
        check_idle("f12_idle");

        // break prefix stays pending until the next byte
        send(8'hF0);
        settle();
        ce_tick();
        check("brk_pending", brk, 1'b1);
        expect_release(0);
        send(8'h07);
        settle();
        check("f12_up", keys, 3'b111);
        check("brk_clear", brk, 1'b0);
        check("f12_toggle_kept", toggle, tog_exp);
        check_idle("f12_rel_idle");

        // del without E0 does not match the extended entry
        send(8'h71);
        settle();
        check("del_noext", keys, 3'b111);

        expect_press(2);
        send(8'hE0);
        check("extd_pending", extd, 1'b1);
        send(8'h71);
        settle();
        check("del_down", keys, 3'b011);

        // both prefixes pending: extended break
        expect_release(2);
        send(8'hE0);
        send(8'hF0);
        send(8'h71);
        settle();
        check("del_up", keys, 3'b111);
        check("del_extd_clear", extd, 1'b0);
        check_idle("del_idle");

        // typematic repeats: one press only
        expect_press(0);
        send(8'h07);
        send(8'h07);
        send(8'h07);
        settle();
        check("typematic_toggle", toggle, tog_exp);
        expect_release(0);
        send(8'hF0);
        send(8'h07);
        settle();
        check_idle("typematic_idle");

        // long hold with HOLD=100
        expect_press(0);
        send(8'h07);
        for (int t = 0; t < 100; t++) ce_tick();
        check("held_early", held, 3'b000);
        ce_tick();
        check("held_rise", held, 3'b001);
        check("held_toggle", toggle, tog_exp);
        expect_release(0);
        send(8'hF0);
        send(8'h07);
        check("held_at_rel", held, 3'b001);
        ce_tick();
        check("held_drop", held, 3'b000);
        ce_tick();
        check_idle("hold_idle");

        // Pause sequence is swallowed entirely
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        settle();
        check("pause_keys", keys, 3'b111);
        check_idle("pause_idle");
        expect_press(1);
        send(8'h14);
        settle();
        check("ctrl_down", keys, 3'b101);

        // BAT: all keys up, no release pulse
        send(8'hAA);
        settle();
        check("bat_keys", keys, 3'b111);
        check("bat_held", held, 3'b000);
        check_idle("bat_idle");

        // reset in the middle of an extended sequence
        expect_press(0);
        send(8'h07);
        settle();
        send(8'hE0);
        check("mid_extd", extd, 1'b1);
        @(negedge clock);
        rst_n = 1'b0;
        #2;
        check("mr_keys", keys, 3'b111);
        check("mr_press", press, 3'b000);
        check("mr_release", released, 3'b000);
        check("mr_toggle", toggle, 3'b000);
        check("mr_held", held, 3'b000);
        check("mr_brk", brk, 1'b0);
        check("mr_extd", extd, 1'b0);
        tog_exp = '0;
        @(negedge clock);
        rst_n = 1'b1;
        settle();
        send(8'h71);
        settle();
        check("mr_del_noext", keys, 3'b111);
        check_idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_hotkeys.md
Name: ps2_hotkeys

Overview:
- Parametrised PS/2 hotkey decoder: watches the scancode byte stream from the ps2 receiver and keeps per-key state for a configurable table of KEYS scancodes.
- Each key has a level, press/release pulses, a toggle and a long-hold flag.
- Generalises the fixed F1/F2/F5/F10/F11/F12/ctrl/alt/del/bs/scroll-lock latches and edge detectors in the board top levels.
- Sits between ps2 and the reset/nmi/rom/vga/save control logic of every board wrapper.

Parameters:
- KEYS, 8, number of table entries.
- CODES, {KEYS{9'h000}}, packed table; entry i = CODES[9*i+8:9*i] = {extended, scancode}.
- HOLDW, 22, width of the per-key hold counters.
- HOLD, 22'd3000000, ce ticks a key must stay down before held asserts (0.5 s at ce = 6 MHz).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- ce, in, 1, clock enable; all state advances only on clock edges with ce=1.
- strb, in, 1, ps2 byte-valid strobe; sampled only when ce=1.
- code, in, 8, ps2 byte, valid with strb.
- keys, out, KEYS, level per entry; 0 = down, 1 = up.
- press, out, KEYS, one-ce pulse on the up->down transition.
- release, out, KEYS, one-ce pulse on the down->up transition.
- toggle, out, KEYS, flips on each press pulse.
- held, out, KEYS, 1 while the key has been down for >= HOLD ce ticks.
- brk, out, 1, break prefix (F0) pending.
- extd, out, 1, extended prefix (E0) pending.

Behaviour:
Reset (async, reset=0):
- keys = all 1; press, release, toggle, held = 0; brk = extd = 0.
- Hold counters = 0; skip counter = 0.

Byte decode (on each ce with strb=1):
- Skip counter != 0: decrement it; byte otherwise ignored. Covers the Pause sequence.
- F0: brk <= 1.
- E0: extd <= 1.
- E1: skip counter <= 7; brk, extd <= 0.
- AA with brk=0 (keyboard BAT / hot-plug): all keys <= 1, no release pulses, brk/extd <= 0.
- Any other byte: for every entry i with CODES[9i+7:9i]==code and CODES[9i+8]==extd, keys[i] <= brk. Then brk <= 0, extd <= 0.
- Duplicate table entries all update together.
- Non-matching bytes only clear the prefixes.

Edge pulses:
- Generated from the registered keys versus its previous-ce copy.
- press[i] = prev_keys[i] & ~keys[i]; release[i] = ~prev_keys[i] & keys[i].
- Both are registered and high for exactly one ce tick.
- The pulse appears on the second ce tick after the strb tick.
- Typematic repeats (make while already down) give no pulse and no toggle.

Toggle:
- toggle[i] <= ~toggle[i] on the same ce tick press[i] is registered.
- Reset alone clears it.

Hold counters:
- Per key, HOLDW bits.
- Counter clears while keys[i]=1; increments on each ce while keys[i]=0; saturates at HOLD.
- held[i] = (counter==HOLD) & ~keys[i], registered.
- Releasing the key drops held on the next ce.
- HOLD=0: held follows ~keys one ce late.

Boundary conditions:
- strb held high across non-ce clocks: counted once only.
- Prefix with no following byte: stays pending indefinitely.
- Byte arriving while both prefixes are set: treated as an extended break.
- Reset asserted mid-sequence: prefixes and skip are lost; keys return to up with no release pulse.
- Outputs never glitch between ce ticks.

Test Plan:
- Table {0,07}=F12, {0,14}=ctrl, {1,71}=del. Send 07 -> keys[0]=0, press[0]=1 for one ce, toggle[0]=1. Send F0 07 -> release[0] pulse, keys[0]=1.
- Send 71 (no prefix) -> no change. Send E0 71 -> keys[2]=0. Send E0 F0 71 -> keys[2]=1, release[2] pulse, extd=0 afterwards.
- Send 07 three times (typematic) -> exactly one press pulse; toggle=1. Release, press again -> toggle=0.
- HOLD=100: hold F12 -> held[0] rises at tick 100 after keys[0] falls (+1 register); send F0 07 -> held[0]=0 next ce.
- Send E1 14 77 E1 F0 14 F0 77 -> no key change (ctrl stays up). Next 14 -> keys[1]=0.
- Press ctrl, then send AA -> keys all 1, no release pulse. Separately, assert reset mid E0 -> all outputs at reset values, extd=0.
